// File: rtl/pin_bus_sequencer_pkg.sv
// Shared types and constants for the TinyTapeout pin bus sequencer.
// Pin drive values for each transfer phase are derived in one helper function.
package pin_bus_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR_HI = 2'd1,
        ST_ADDR_LO = 2'd2,
        ST_DATA    = 2'd3
    } state_e;

    localparam int RW_BIT  = 0;
    localparam int ALE_BIT = 1;

    localparam logic [7:0] OE_NONE = 8'h00;
    localparam logic [7:0] OE_CTRL = 8'h03;
    localparam logic [7:0] OE_ALL  = 8'hFF;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
    } req_t;

    typedef struct packed {
        logic [7:0] uo;
        logic [7:0] uio;
        logic [7:0] oe;
    } pins_t;

    // Pin image that should be visible while the bus sits in state st.
    function automatic pins_t pins_for(input state_e st, input req_t r);
        pins_t p;
        p.uo  = 8'h00;
        p.uio = 8'h00;
        p.oe  = OE_NONE;
        case (st)
            ST_IDLE: begin
                p.oe = OE_NONE;
            end
            ST_ADDR_HI: begin
                p.uo           = r.addr[15:8];
                p.uio[ALE_BIT] = 1'b1;
                p.uio[RW_BIT]  = r.rw;
                p.oe           = OE_CTRL;
            end
            ST_ADDR_LO: begin
                p.uo          = r.addr[7:0];
                p.uio[RW_BIT] = r.rw;
                p.oe          = OE_CTRL;
            end
            ST_DATA: begin
                p.uo = r.addr[7:0];
                if (r.rw) begin
                    p.uio = 8'h00;
                    p.oe  = OE_NONE;
                end else begin
                    p.uio = r.wdata;
                    p.oe  = OE_ALL;
                end
            end
            default: begin
                p.oe = OE_NONE;
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pin_bus_sequencer_bus_wait_timer.sv
// Registers the external ready line and counts DATA-phase wait cycles,
// flagging completion either on ready or when the wait budget runs out.
module bus_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ext_rdy,
    input  logic in_data,
    output logic rdy_o,
    output logic done_o,
    output logic timeout_o
);

    localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

    logic       rdy_q, rdy_d;
    logic [7:0] cnt_q, cnt_d;
    logic       at_max_s;

    // Completion decode and saturating wait counter, cleared whenever DATA ends.
    always_comb begin
        rdy_d     = ext_rdy;
        at_max_s  = (cnt_q == WAIT_MAX_C);
        done_o    = in_data && (rdy_q || at_max_s);
        timeout_o = in_data && !rdy_q && at_max_s;
        if (!in_data || done_o) begin
            cnt_d = 8'd0;
        end else if (!rdy_q && !at_max_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        rdy_o = rdy_q;
    end

    // Ready synchroniser stage and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            rdy_q <= rdy_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pin_bus_sequencer.sv
// Sequences one 16-bit memory request onto the shared pins as ADDR_HI, ADDR_LO,
// DATA phases and returns read data to the core with a one-cycle response pulse.
module pin_bus_sequencer
    import pin_bus_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_MAX  = 15,
    parameter logic [7:0]  IDLE_FILL = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_rw,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    input  logic        ext_rdy,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uo_out,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe,
    output logic        busy
);

    state_e     state_q, state_d;
    req_t       req_q, req_d;
    pins_t      pins_q, pins_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_timeout_q, rsp_timeout_d;
    logic       in_data_s, done_s, timeout_s, rdy_s, accept_s;

    assign in_data_s = (state_q == ST_DATA);

    bus_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .ext_rdy   (ext_rdy),
        .in_data   (in_data_s),
        .rdy_o     (rdy_s),
        .done_o    (done_s),
        .timeout_o (timeout_s)
    );

    // Next state, request latch, pin image for the upcoming state, and response.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;

        // Ready depends only on state and the wait timer, never on req_valid.
        req_ready = (state_q == ST_IDLE) || (in_data_s && done_s);
        accept_s  = req_valid && req_ready;

        if (accept_s) begin
            req_d.addr  = req_addr;
            req_d.rw    = req_rw;
            req_d.wdata = req_wdata;
        end else begin
            req_d = req_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ADDR_HI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR_HI: begin
                state_d = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (done_s) begin
                    state_d       = accept_s ? ST_ADDR_HI : ST_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = timeout_s;
                    if (req_q.rw) begin
                        rsp_rdata_d = timeout_s ? IDLE_FILL : uio_in;
                    end else begin
                        rsp_rdata_d = rsp_rdata_q;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pins_d = pins_for(state_d, req_d);
    end

    // Architectural state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            pins_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            pins_q        <= pins_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign uo_out      = pins_q.uo;
    assign uio_out     = pins_q.uio;
    assign uio_oe      = pins_q.oe;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pin_bus_sequencer.sv
// Directed bench for pin_bus_sequencer: pin-phase checks inline, responses
// checked by a monitor against a scoreboard queue filled at request acceptance.
module tb_pin_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_rw;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic        ext_rdy;
    logic [7:0]  uio_in;
    logic [7:0]  uo_out;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic        busy;

    typedef struct {
        logic [7:0] rdata;
        logic       to;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    pin_bus_sequencer #(
        .WAIT_MAX  (15),
        .IDLE_FILL (8'hFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_rw      (req_rw),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .ext_rdy     (ext_rdy),
        .uio_in      (uio_in),
        .uo_out      (uo_out),
        .uio_out     (uio_out),
        .uio_oe      (uio_oe),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, e.rdata});
                chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.to});
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic start_req(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                             input logic [7:0] er, input logic eto, input int waits,
                             input bit expect_rsp);
        bit got;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = a;
        req_rw    = rw;
        req_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept", {31'h0, got}, 32'd1);
        if (got && expect_rsp) sb_q.push_back('{er, eto, cyc + 4 + waits});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        req_rw    = 1'b0;
        req_wdata = 8'h00;
    endtask

    task automatic chk_pins(input string name, input logic [7:0] uo, input logic [7:0] uio,
                            input logic [7:0] oe);
        chk({name, "_uo"}, {24'h0, uo_out}, {24'h0, uo});
        chk({name, "_uio"}, {24'h0, uio_out}, {24'h0, uio});
        chk({name, "_oe"}, {24'h0, uio_oe}, {24'h0, oe});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        req_rw    = 1'b0;
        req_wdata = 8'h00;
        ext_rdy   = 1'b1;
        uio_in    = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        chk_pins("reset", 8'h00, 8'h00, 8'h00);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("reset_rdata", {24'h0, rsp_rdata}, 32'd0);
        chk("reset_timeout", {31'h0, rsp_timeout}, 32'd0);
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_ready", {31'h0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Read 0x12A5, no waits.
        uio_in = 8'h3C;
        start_req(16'h12A5, 1'b1, 8'h00, 8'h3C, 1'b0, 0, 1'b1);
        @(negedge clk);
        chk_pins("rd_ahi", 8'h12, 8'h03, 8'h03);
        chk("rd_ahi_busy", {31'h0, busy}, 32'd1);
        @(negedge clk);
        chk_pins("rd_alo", 8'hA5, 8'h01, 8'h03);
        chk("rd_alo_ready", {31'h0, req_ready}, 32'd0);
        @(negedge clk);
        chk_pins("rd_data", 8'hA5, 8'h00, 8'h00);
        chk("rd_data_ready", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        chk_pins("rd_idle", 8'h00, 8'h00, 8'h00);
        chk("rd_idle_busy", {31'h0, busy}, 32'd0);

        // Write 0xFF00 <- 0x5A; read data register must hold.
        start_req(16'hFF00, 1'b0, 8'h5A, 8'h3C, 1'b0, 0, 1'b1);
        @(negedge clk);
        chk_pins("wr_ahi", 8'hFF, 8'h02, 8'h03);
        @(negedge clk);
        chk_pins("wr_alo", 8'h00, 8'h00, 8'h03);
        @(negedge clk);
        chk_pins("wr_data", 8'h00, 8'h5A, 8'hFF);
        repeat (2) @(negedge clk);

        // Back-to-back reads with req_valid held high.
        uio_in = 8'h81;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = 16'h0001;
        req_rw    = 1'b1;
        @(negedge clk);
        chk("b2b_ready_idle", {31'h0, req_ready}, 32'd1);
        sb_q.push_back('{8'h81, 1'b0, cyc + 4});
        @(posedge clk); #1;
        req_addr = 16'h0002;
        @(negedge clk);
        chk_pins("b2b_ahi1", 8'h00, 8'h03, 8'h03);
        @(negedge clk);
        chk("b2b_alo1_ready", {31'h0, req_ready}, 32'd0);
        @(negedge clk);
        chk_pins("b2b_data1", 8'h01, 8'h00, 8'h00);
        chk("b2b_data1_ready", {31'h0, req_ready}, 32'd1);
        sb_q.push_back('{8'h82, 1'b0, cyc + 4});
        @(posedge clk); #1;
        req_valid = 1'b0;
        uio_in    = 8'h82;
        @(negedge clk);
        chk_pins("b2b_ahi2", 8'h00, 8'h03, 8'h03);
        chk("b2b_ahi2_busy", {31'h0, busy}, 32'd1);
        @(negedge clk);
        chk_pins("b2b_alo2", 8'h02, 8'h01, 8'h03);
        repeat (3) @(negedge clk);

        // Three wait cycles, then ready.
        ext_rdy = 1'b0;
        uio_in  = 8'h77;
        start_req(16'h3456, 1'b1, 8'h00, 8'h77, 1'b0, 3, 1'b1);
        repeat (3) @(negedge clk);
        chk("wait_d1_ready", {31'h0, req_ready}, 32'd0);
        @(negedge clk);
        chk("wait_d2_ready", {31'h0, req_ready}, 32'd0);
        @(negedge clk);
        chk("wait_d3_ready", {31'h0, req_ready}, 32'd0);
        chk("wait_d3_busy", {31'h0, busy}, 32'd1);
        ext_rdy = 1'b1;
        @(negedge clk);
        chk("wait_d4_ready", {31'h0, req_ready}, 32'd1);
        chk_pins("wait_d4", 8'h56, 8'h00, 8'h00);
        repeat (3) @(negedge clk);

        // Timeout with ext_rdy held low.
        ext_rdy = 1'b0;
        uio_in  = 8'h11;
        start_req(16'h4321, 1'b1, 8'h00, 8'hFF, 1'b1, 15, 1'b1);
        repeat (12) @(negedge clk);
        chk("to_mid_ready", {31'h0, req_ready}, 32'd0);
        chk("to_mid_busy", {31'h0, busy}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("to_idle_busy", {31'h0, busy}, 32'd0);
        chk_pins("to_idle", 8'h00, 8'h00, 8'h00);

        // Reset during ADDR_LO abandons the transfer.
        ext_rdy = 1'b1;
        start_req(16'hBEEF, 1'b1, 8'h00, 8'h00, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        chk_pins("rst_alo_pre", 8'hEF, 8'h01, 8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        chk_pins("rst_async", 8'h00, 8'h00, 8'h00);
        chk("rst_async_busy", {31'h0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh read after reset.
        uio_in = 8'hC3;
        start_req(16'h00C3, 1'b1, 8'h00, 8'hC3, 1'b0, 0, 1'b1);
        @(negedge clk);
        chk_pins("post_rst_ahi", 8'h00, 8'h03, 8'h03);

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        repeat (5) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pin_bus_sequencer.md
Name: pin_bus_sequencer

Overview:
Downstream stage of the core top level. Takes one 16-bit memory request per transaction from the core (address mux output, rw, store data) and sequences it onto the shared TinyTapeout pins as a three-phase transfer: ADDR_HI, ADDR_LO, DATA. It captures read data from uio_in and returns it to the core with a valid/ready handshake. It also supports external wait states and a timeout.

Parameters:
WAIT_MAX, 15, maximum DATA-phase cycles with ext_rdy low before forced completion (1..255)
IDLE_FILL, 8'hFF, read data returned on timeout

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
req_valid  input  1  core presents a request
req_ready  output  1  sequencer accepts request this cycle
req_addr  input  16  memory address
req_rw  input  1  1=read, 0=write
req_wdata  input  8  store data (writes only)
rsp_valid  output  1  one-cycle pulse: transaction complete
rsp_rdata  output  8  read data; held until next rsp_valid
rsp_timeout  output  1  qualifies rsp_valid: completed by timeout
ext_rdy  input  1  external wait line (from ui_in), 1=ready
uo_out  output  8  address byte pins
uio_out  output  8  data / control pins
uio_oe  output  8  pin output enables, 1=drive
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; uo_out=0, uio_out=0, uio_oe=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, latched request cleared, wait counter=0. Reset mid-transaction abandons it with no rsp_valid. First state change is on the first clk edge after release.
- ext_rdy is registered once (rdy_q). Only rdy_q is used internally.
- States: IDLE -> ADDR_HI -> ADDR_LO -> DATA -> (ADDR_HI | IDLE).
- Accept: handshake when req_valid & req_ready. The request (addr, rw, wdata) is latched at the accepting edge.
  - req_ready=1 in IDLE.
  - req_ready=1 in DATA on the completing cycle (rdy_q=1 or counter reached WAIT_MAX), enabling back-to-back transfers.
  - req_ready=0 otherwise. req_ready is combinational from state, rdy_q and counter only; it never depends on req_valid.
- Pin values are all registered and are the values for the current state:
  - IDLE: uo_out=0, uio_out=0, uio_oe=8'h00.
  - ADDR_HI: uo_out=addr[15:8], uio_out={6'b0,1'b1,rw}, uio_oe=8'h03. Bit1 is the high-byte latch strobe, bit0 is rw.
  - ADDR_LO: uo_out=addr[7:0], uio_out={6'b0,1'b0,rw}, uio_oe=8'h03.
  - DATA write: uo_out=addr[7:0], uio_out=wdata, uio_oe=8'hFF.
  - DATA read: uo_out=addr[7:0], uio_out=0, uio_oe=8'h00.
- DATA completion:
  - On the first DATA cycle with rdy_q=1: rsp_valid=1 on the next cycle, rsp_timeout=0. For reads, rsp_rdata=uio_in sampled on that completing edge. For writes, rsp_rdata is unchanged.
  - Wait counter: increments each DATA cycle with rdy_q=0 and clears on leaving DATA. When it equals WAIT_MAX, the transaction completes the same way with rsp_timeout=1; reads return IDLE_FILL.
- Latency: request accepted at edge T gives ADDR_HI in T..T+1, ADDR_LO T+1..T+2, DATA T+2..T+3. With no waits, rsp_valid is high in the cycle after edge T+3: 4 cycles accept-to-response, 3-cycle throughput back-to-back.
- Exit from DATA on completion: next state is ADDR_HI if a new request was accepted on that edge, else IDLE.
- Simultaneous events:
  - Completion and new accept on the same edge: the new request is latched and the old response is still issued.
  - rsp_valid is never suppressed by a new accept.
- The core need not hold req_* after acceptance.
- busy=1 in ADDR_HI, ADDR_LO, DATA.

Decomposition:
- Shared include inc/bus_if_defs.vh:
  - state encodings (2 bits: IDLE=0, ADDR_HI=1, ADDR_LO=2, DATA=3)
  - uio bit positions (RW_BIT=0, ALE_BIT=1)
  - OE constants (OE_NONE=8'h00, OE_CTRL=8'h03, OE_ALL=8'hFF)
- One sub-module is natural: bus_wait_timer. It holds the rdy_q register plus the saturating wait counter, takes WAIT_MAX, and outputs done/timeout.

Test Plan:
- Read 16'h12A5, ext_rdy=1, uio_in=8'h3C in DATA -> uo_out 12,A5,A5 on successive cycles; uio_out[1:0] 2'b11 then 2'b01; uio_oe 03,03,00; rsp_valid 4 cycles after accept with rsp_rdata=3C, rsp_timeout=0.
- Write 16'hFF00 data 8'h5A -> DATA phase uio_out=5A, uio_oe=FF, uio_out[0]=0 in address phases; rsp_valid after 4 cycles.
- Back-to-back reads 0x0001 then 0x0002, req_valid held high -> second ADDR_HI directly follows first DATA; rsp_valid pulses 3 cycles apart; no IDLE between.
- Read with ext_rdy low 3 cycles then high, uio_in=8'h77 -> DATA held 4 cycles, rsp_rdata=77, rsp_timeout=0, req_ready low until completion.
- ext_rdy held low, WAIT_MAX=15 -> completion after 15 wait cycles; rsp_timeout=1, rsp_rdata=FF; state returns to IDLE.
- rst_n pulsed low during ADDR_LO -> pins and uio_oe go 0 immediately (async); no rsp_valid; after release, a fresh read completes normally.
